// File: rtl/reg_skid_hs.sv
// reg_skid_hs: elastic valid/ready pipeline stage with a one-entry skid buffer.
//
// Purpose:
//   Decouples an upstream producer from downstream backpressure. The stage
//   holds up to two words: the main register drives the output and the skid
//   register catches the word that was already in flight when the consumer
//   stalled. in_ready comes straight from a flop (~skid_v), so there is no
//   combinational path from out_ready to in_ready. While the consumer accepts,
//   the stage streams one word per cycle with one cycle of latency.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   arst_n     synchronous active-low reset, highest priority
//   flush      synchronous clear of buffered words (data registers keep values)
//   in_valid   upstream word present on in_data
//   in_data    upstream payload [DATA_W-1:0]
//   in_ready   stage can accept a word this cycle
//   out_valid  out_data holds a valid word
//   out_data   payload toward downstream [DATA_W-1:0]
//   out_ready  downstream accepts out_data this cycle
//   count      occupancy 0, 1 or 2
module reg_skid_hs #(
  parameter int                 DATA_W     = 20,
  parameter logic [DATA_W-1:0]  PRESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  // Occupancy encoding {skid_v, main_v}; 2'b10 cannot be reached.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              main_v;
  logic              skid_v;

  logic              in_fire_s;
  logic              out_fire_s;

  // Handshake qualifiers, built only from flop outputs and the inputs.
  always_comb begin
    in_fire_s  = in_valid & ~skid_v;
    out_fire_s = main_v & out_ready;
  end

  // Occupancy and data register updates.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= PRESET_VAL;
      skid_q <= PRESET_VAL;
    end else if (flush) begin
      // Drop buffered words; data registers intentionally keep their contents.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case ({skid_v, main_v})
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_q <= in_data;
            main_v <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_q <= in_data;
          end else if (in_fire_s) begin
            // Consumer stalled with a word in flight: park it in the skid slot.
            skid_q <= in_data;
            skid_v <= 1'b1;
          end else if (out_fire_s) begin
            main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            main_q <= skid_q;
            skid_v <= 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: fall back to an empty stage.
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are taken directly from the flops.
  always_comb begin
    out_data  = main_q;
    out_valid = main_v;
    in_ready  = ~skid_v;
    count     = {1'b0, main_v} + {1'b0, skid_v};
  end

endmodule

// File: tb/tb_reg_skid_hs.sv
// Self-checking bench for reg_skid_hs (DATA_W=8, PRESET_VAL=8'h5A).
// A queue-based reference model (capacity two, FIFO order) predicts the
// outputs after every rising edge; directed steps add fixed expectations.
module tb_reg_skid_hs;

  localparam int         DW     = 8;
  localparam logic [7:0] PRESET = 8'h5A;

  logic          clk;
  logic          arst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    count;

  int total;
  int bad;

  // Reference model state.
  logic [7:0] mq[$];
  logic [7:0] shown;

  reg_skid_hs #(.DATA_W(DW), .PRESET_VAL(PRESET)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare every output against it.
  task automatic step();
    bit do_in;
    bit do_out;
    @(posedge clk);
    if (!arst_n) begin
      mq.delete();
      shown = PRESET;
    end else if (flush) begin
      mq.delete();
    end else begin
      do_in  = in_valid && (mq.size() < 2);
      do_out = (mq.size() > 0) && out_ready;
      if (do_out) void'(mq.pop_front());
      if (do_in) mq.push_back(in_data);
    end
    if (mq.size() > 0) shown = mq[0];
    #1;
    chk("m_out_valid", out_valid, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("m_in_ready", in_ready, (mq.size() < 2) ? 32'd1 : 32'd0);
    chk("m_count", count, mq.size());
    chk("m_out_data", out_data, shown);
  endtask

  initial begin
    total = 0;
    bad = 0;
    shown = PRESET;
    arst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;

    // Reset for two cycles.
    step();
    step();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_count", count, 32'd0);
    chk("rst_out_data", out_data, 32'h5A);

    // Streaming 01..08 with the consumer always ready.
    arst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      step();
      chk("stream_data", out_data, i);
      chk("stream_count", count, 32'd1);
      chk("stream_in_ready", in_ready, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", count, 32'd0);

    // Backpressure: A1, A2 fill the stage, A3 is refused.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA1;
    step();
    in_data = 8'hA2;
    step();
    chk("bp_count", count, 32'd2);
    chk("bp_in_ready", in_ready, 32'd0);
    chk("bp_hold_a1", out_data, 32'hA1);
    in_data = 8'hA3;
    step();
    chk("bp_full_count", count, 32'd2);
    chk("bp_full_data", out_data, 32'hA1);
    out_ready = 1'b1;
    step();
    chk("bp_drain_a2", out_data, 32'hA2);
    chk("bp_drain_ready", in_ready, 32'd1);
    step();
    chk("bp_drain_a3", out_data, 32'hA3);
    chk("bp_drain_count", count, 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid, 32'd0);

    // Simultaneous accept and drain while holding one word.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    step();
    in_data = 8'h11;
    out_ready = 1'b1;
    step();
    chk("sim_data", out_data, 32'h11);
    chk("sim_count", count, 32'd1);
    chk("sim_in_ready", in_ready, 32'd1);
    in_valid = 1'b0;
    step();

    // Flush while full, coincident with an offered word.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hB1;
    step();
    in_data = 8'hB2;
    step();
    in_data = 8'hEE;
    flush = 1'b1;
    step();
    chk("flush_count", count, 32'd0);
    chk("flush_out_valid", out_valid, 32'd0);
    chk("flush_in_ready", in_ready, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("flush_no_ee", out_valid, 32'd0);
    chk("flush_data_held", out_data, 32'hB1);

    // Reset while full with the consumer ready.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hC1;
    step();
    in_data = 8'hC2;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    arst_n = 1'b0;
    step();
    chk("rstfull_out_valid", out_valid, 32'd0);
    chk("rstfull_count", count, 32'd0);
    chk("rstfull_data", out_data, 32'h5A);

    // A reset pulse between edges must not disturb the stage.
    arst_n = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hD1;
    step();
    in_valid = 1'b0;
    #2 arst_n = 1'b0;
    #2 arst_n = 1'b1;
    chk("glitch_now", count, 32'd1);
    step();
    chk("glitch_edge_valid", out_valid, 32'd1);
    chk("glitch_edge_data", out_data, 32'hD1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? 8'($urandom) : 8'hxx;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      arst_n    = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
